blk_9efaff: RTL and testbench

VID_PHY_CONTROLLER_V2_2_20_GT_TX_TMDSCLK_PATGEN_CTRL -- requirements
Module: vid_phy_controller_v2_2_20_gt_tx_tmdsclk_patgen_ctrl

---
 rtl/blk_9efaff.sv | 173 +++++++++++++++++
 tb/tb_blk_9efaff.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/blk_9efaff.sv
// TX TMDS-clock pattern generator control: sequences disable / ratio load /
// GT ready wait / enable on each reconfiguration request, with recovery and timeout.
module blk_9efaff #(
  parameter int SETTLE_CYCLES = 16,
  parameter int RDY_TIMEOUT   = 4096
) (
  input  logic       CLK_IN,
  input  logic       RST_N_IN,
  input  logic       CFG_REQ_IN,
  input  logic [2:0] CFG_RATIO_IN,
  input  logic       CFG_EN_IN,
  input  logic       TX_RESETDONE_IN,
  output logic       CTRL_EN_OUT,
  output logic [2:0] CTRL_RATIO_OUT,
  output logic       CFG_BUSY_OUT,
  output logic       CFG_DONE_OUT,
  output logic       CFG_ERR_OUT
);

  localparam int SW = $clog2(SETTLE_CYCLES + 1);
  localparam int RW = $clog2(RDY_TIMEOUT + 1);
  localparam logic [SW-1:0] SLAST = SW'(SETTLE_CYCLES - 1);
  localparam logic [RW-1:0] RLAST = RW'(RDY_TIMEOUT - 1);

  typedef enum logic [2:0] {
    ST_IDLE, ST_DISABLE, ST_LOAD, ST_WAIT_RDY, ST_ENABLE, ST_DONE
  } state_t;

  state_t        state_q;
  logic [SW-1:0] settleCnt_q;
  logic [RW-1:0] rdyCnt_q;
  logic [2:0]    capRatio_q;
  logic          capEn_q;
  logic          recover_q;
  logic          pendValid_q;
  logic [2:0]    pendRatio_q;
  logic          pendEn_q;
  logic          ctrlEn_q;
  logic [2:0]    ctrlRatio_q;
  logic          done_q;
  logic          err_q;

  logic ratioLegal;
  logic reqLegal;
  logic reqIllegal;
  logic settleLast;
  logic rdyLast;

  assign ratioLegal = (CFG_RATIO_IN != 3'd0) && (CFG_RATIO_IN <= 3'd5);
  assign reqLegal   = CFG_REQ_IN && ratioLegal;
  assign reqIllegal = CFG_REQ_IN && !ratioLegal;
  assign settleLast = (settleCnt_q == SLAST);
  assign rdyLast    = (rdyCnt_q == RLAST);

  always_ff @(posedge CLK_IN or negedge RST_N_IN) begin
    if (!RST_N_IN) begin
      state_q     <= ST_IDLE;
      settleCnt_q <= '0;
      rdyCnt_q    <= '0;
      capRatio_q  <= 3'd0;
      capEn_q     <= 1'b0;
      recover_q   <= 1'b0;
      pendValid_q <= 1'b0;
      pendRatio_q <= 3'd0;
      pendEn_q    <= 1'b0;
      ctrlEn_q    <= 1'b0;
      ctrlRatio_q <= 3'd0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= reqIllegal;
      if (reqLegal && (state_q != ST_IDLE)) begin
        pendValid_q <= 1'b1;
        pendRatio_q <= CFG_RATIO_IN;
        pendEn_q    <= CFG_EN_IN;
      end
      case (state_q)
        ST_IDLE: begin
          // Link lost while enabled: recovery wins, a same-cycle request waits in the slot.
          if (ctrlEn_q && !TX_RESETDONE_IN) begin
            state_q     <= ST_DISABLE;
            recover_q   <= 1'b1;
            capEn_q     <= 1'b1;
            ctrlEn_q    <= 1'b0;
            settleCnt_q <= '0;
            if (reqLegal) begin
              pendValid_q <= 1'b1;
              pendRatio_q <= CFG_RATIO_IN;
              pendEn_q    <= CFG_EN_IN;
            end
          end else if (reqLegal || pendValid_q) begin
            state_q     <= ST_DISABLE;
            recover_q   <= 1'b0;
            ctrlEn_q    <= 1'b0;
            settleCnt_q <= '0;
            pendValid_q <= 1'b0;
            capRatio_q  <= reqLegal ? CFG_RATIO_IN : pendRatio_q;
            capEn_q     <= reqLegal ? CFG_EN_IN : pendEn_q;
          end
        end
        ST_DISABLE: begin
          if (settleLast) begin
            settleCnt_q <= '0;
            rdyCnt_q    <= '0;
            if (recover_q) begin
              state_q <= ST_WAIT_RDY;
            end else begin
              state_q     <= ST_LOAD;
              ctrlRatio_q <= capRatio_q;
            end
          end else if (settleCnt_q != '1) begin
            settleCnt_q <= settleCnt_q + 1'b1;
          end
        end
        ST_LOAD: begin
          if (settleLast) begin
            state_q  <= ST_WAIT_RDY;
            rdyCnt_q <= '0;
          end else if (settleCnt_q != '1) begin
            settleCnt_q <= settleCnt_q + 1'b1;
          end
        end
        ST_WAIT_RDY: begin
          if (TX_RESETDONE_IN) begin
            settleCnt_q <= '0;
            if (capEn_q) begin
              state_q  <= ST_ENABLE;
              ctrlEn_q <= 1'b1;
            end else begin
              state_q <= ST_DONE;
              done_q  <= !reqIllegal;
            end
          end else if (rdyLast) begin
            state_q   <= ST_IDLE;
            err_q     <= 1'b1;
            ctrlEn_q  <= 1'b0;
            recover_q <= 1'b0;
          end else if (rdyCnt_q != '1) begin
            rdyCnt_q <= rdyCnt_q + 1'b1;
          end
        end
        ST_ENABLE: begin
          if (settleLast) begin
            settleCnt_q <= '0;
            if (recover_q) begin
              state_q   <= ST_IDLE;
              recover_q <= 1'b0;
            end else begin
              state_q <= ST_DONE;
              done_q  <= !reqIllegal;
            end
          end else if (settleCnt_q != '1) begin
            settleCnt_q <= settleCnt_q + 1'b1;
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign CTRL_EN_OUT    = ctrlEn_q;
  assign CTRL_RATIO_OUT = ctrlRatio_q;
  assign CFG_BUSY_OUT   = (state_q != ST_IDLE);
  assign CFG_DONE_OUT   = done_q;
  assign CFG_ERR_OUT    = err_q;

endmodule

// File: tb/tb_blk_9efaff.sv
// Scoreboard bench for blk_9efaff: expected DONE/ERR events are predicted from
// the sequence timing rules and matched against the DUT's pulses by a monitor.
module tb_blk_9efaff;

  localparam int S = 4;
  localparam int T = 8;

  typedef struct packed {
    logic       isErr;
    int         cyc;
    logic [2:0] ratio;
    logic       en;
  } event_t;

  logic       clk = 1'b0;
  logic       rstN = 1'b0;
  logic       req = 1'b0;
  logic [2:0] ratioIn = 3'd0;
  logic       enIn = 1'b0;
  logic       rdy = 1'b1;
  logic       enOut;
  logic [2:0] ratioOut;
  logic       busy;
  logic       done;
  logic       err;

  int     cyc = 0;
  int     checks = 0;
  int     errors = 0;
  event_t sb[$];
  logic [2:0] modelRatio = 3'd0;
  logic       modelEn = 1'b0;

  blk_9efaff #(.SETTLE_CYCLES(S), .RDY_TIMEOUT(T)) dut (
    .CLK_IN(clk),
    .RST_N_IN(rstN),
    .CFG_REQ_IN(req),
    .CFG_RATIO_IN(ratioIn),
    .CFG_EN_IN(enIn),
    .TX_RESETDONE_IN(rdy),
    .CTRL_EN_OUT(enOut),
    .CTRL_RATIO_OUT(ratioOut),
    .CFG_BUSY_OUT(busy),
    .CFG_DONE_OUT(done),
    .CFG_ERR_OUT(err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  task automatic pushEvent(input logic isErr, input int at, input logic [2:0] r, input logic e);
    event_t ev;
    ev.isErr = isErr;
    ev.cyc   = at;
    ev.ratio = r;
    ev.en    = e;
    sb.push_back(ev);
  endtask

  // Monitor: every DONE/ERR pulse must match the oldest predicted event.
  always @(posedge clk) begin
    event_t exp;
    #1;
    if (rstN && done && err) begin
      checks++;
      errors++;
      $display("[TB] FAIL doneErrExclusive: both pulses high at cycle %0d", cyc);
    end
    if (rstN && (done || err)) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("[TB] FAIL unexpectedEvent: got done=%0b err=%0b at cycle %0d, expected none", done, err, cyc);
      end else begin
        exp = sb.pop_front();
        if (err !== exp.isErr || cyc != exp.cyc || ratioOut !== exp.ratio || enOut !== exp.en) begin
          errors++;
          $display("[TB] FAIL eventMatch: got err=%0b cyc=%0d ratio=%0d en=%0b, expected err=%0b cyc=%0d ratio=%0d en=%0b",
                   err, cyc, ratioOut, enOut, exp.isErr, exp.cyc, exp.ratio, exp.en);
        end
      end
    end
  end

  task automatic waitIdle(input string name);
    int k;
    k = 0;
    @(negedge clk);
    while (busy && k < 200) begin
      @(negedge clk);
      k++;
    end
    checkOutput({name, "_idleReached"}, busy, 0);
  endtask

  // One request from IDLE; rdy rises d cycles into WAIT_RDY (d >= T means timeout).
  task automatic applyStimulus(input logic [2:0] r, input logic e, input int d);
    int  n;
    bit  legal;
    legal = (r >= 3'd1) && (r <= 3'd5);
    @(negedge clk);
    n = cyc;
    req = 1'b1;
    ratioIn = r;
    enIn = e;
    if (!legal) begin
      pushEvent(1'b1, n + 1, modelRatio, modelEn);
    end else if (d < T) begin
      pushEvent(1'b0, n + (e ? 3 * S + 2 : 2 * S + 2) + d, r, e);
      modelRatio = r;
      modelEn = e;
    end else begin
      pushEvent(1'b1, n + 2 * S + T + 1, r, 1'b0);
      modelRatio = r;
      modelEn = 1'b0;
    end
    @(negedge clk);
    req = 1'b0;
    if (legal) begin
      rdy = 1'b0;
      repeat (2 * S + d) @(negedge clk);
      rdy = 1'b1;
    end
    waitIdle("txn");
    @(negedge clk);
  endtask

  initial begin
    int n;
    int c;
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int n;
    int c;
    logic [2:0] r;
    logic e;
    int sel;
    int d;

    repeat (3) @(negedge clk);
    checkOutput("rstEn", enOut, 0);
    checkOutput("rstRatio", ratioOut, 0);
    checkOutput("rstBusy", busy, 0);
    checkOutput("rstDone", done, 0);
    checkOutput("rstErr", err, 0);
    rstN = 1'b1;
    repeat (2) @(negedge clk);

    // Nominal sequence with ready already high, sampled cycle by cycle.
    @(negedge clk);
    n = cyc;
    req = 1'b1; ratioIn = 3'd3; enIn = 1'b1;
    pushEvent(1'b0, n + 3 * S + 2, 3'd3, 1'b1);
    for (int k = 1; k <= 3 * S + 3; k++) begin
      @(negedge clk);
      req = 1'b0;
      checkOutput($sformatf("nomEn_c%0d", k), enOut, (k >= 2 * S + 2) ? 1 : 0);
      checkOutput($sformatf("nomRatio_c%0d", k), ratioOut, (k >= S + 1) ? 3 : 0);
      checkOutput($sformatf("nomBusy_c%0d", k), busy, (k <= 3 * S + 2) ? 1 : 0);
    end
    modelRatio = 3'd3;
    modelEn = 1'b1;

    applyStimulus(3'd5, 1'b1, 11);
    applyStimulus(3'd2, 1'b1, T);
    applyStimulus(3'd1, 1'b0, 0);
    applyStimulus(3'd7, 1'b1, 0);

    // Pending slot: latest legal request while busy replaces the earlier one.
    @(negedge clk);
    n = cyc;
    req = 1'b1; ratioIn = 3'd1; enIn = 1'b1;
    pushEvent(1'b0, n + 3 * S + 2, 3'd1, 1'b1);
    pushEvent(1'b0, n + 3 * S + 3 + 3 * S + 2, 3'd4, 1'b1);
    @(negedge clk); req = 1'b0;
    @(negedge clk); req = 1'b1; ratioIn = 3'd2;
    @(negedge clk); req = 1'b0;
    @(negedge clk); req = 1'b1; ratioIn = 3'd4;
    @(negedge clk); req = 1'b0;
    repeat (6 * S + 6) @(negedge clk);
    waitIdle("pending");
    modelRatio = 3'd4;
    modelEn = 1'b1;

    // Illegal request during the last ENABLE cycle: error replaces DONE.
    @(negedge clk);
    n = cyc;
    req = 1'b1; ratioIn = 3'd2; enIn = 1'b1;
    pushEvent(1'b1, n + 3 * S + 2, 3'd2, 1'b1);
    @(negedge clk); req = 1'b0;
    repeat (3 * S) @(negedge clk);
    req = 1'b1; ratioIn = 3'd0;
    @(negedge clk); req = 1'b0;
    waitIdle("prio");
    modelRatio = 3'd2;

    // Recovery with a same-cycle request parked in the pending slot.
    @(negedge clk);
    c = cyc;
    rdy = 1'b0;
    req = 1'b1; ratioIn = 3'd5; enIn = 1'b0;
    pushEvent(1'b0, c + 2 * S + 2 + 2 * S + 2, 3'd5, 1'b0);
    @(negedge clk);
    rdy = 1'b1; req = 1'b0;
    checkOutput("recEnDrop", enOut, 0);
    checkOutput("recBusy", busy, 1);
    repeat (S) @(negedge clk);
    checkOutput("recEnStillLow", enOut, 0);
    @(negedge clk);
    checkOutput("recEnBack", enOut, 1);
    checkOutput("recRatioKept", ratioOut, 2);
    repeat (S) @(negedge clk);
    checkOutput("recIdle", busy, 0);
    repeat (2 * S + 4) @(negedge clk);
    waitIdle("recover");
    modelRatio = 3'd5;
    modelEn = 1'b0;

    // Asynchronous reset in the middle of LOAD.
    @(negedge clk);
    req = 1'b1; ratioIn = 3'd4; enIn = 1'b1;
    @(negedge clk); req = 1'b0;
    repeat (S + 1) @(negedge clk);
    #2 rstN = 1'b0;
    #1;
    checkOutput("midRstEn", enOut, 0);
    checkOutput("midRstRatio", ratioOut, 0);
    checkOutput("midRstBusy", busy, 0);
    checkOutput("midRstDone", done, 0);
    checkOutput("midRstErr", err, 0);
    @(negedge clk);
    rstN = 1'b1;
    modelRatio = 3'd0;
    modelEn = 1'b0;
    applyStimulus(3'd3, 1'b1, 2);

    for (int i = 0; i < 16; i++) begin
      r = 3'($urandom_range(0, 7));
      e = 1'($urandom_range(0, 1));
      sel = $urandom_range(0, 4);
      d = (sel == 0) ? T : $urandom_range(0, 6);
      applyStimulus(r, e, d);
    end

    repeat (5) @(negedge clk);
    checkOutput("scoreboardDrained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
